calc_input_sequencer: RTL and testbench

CALC_INPUT_SEQUENCER -- requirements
Module: calc_input_sequencer

---
 rtl/calc_input_sequencer.sv | 97 +++++++++
 tb/tb_calc_input_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_input_sequencer.sv
// Input sequencer for a small calculator: synchronizes the raw KEY/SW inputs,
// debounces them, and commits a stable {OP,A,B} word with a one-cycle LOAD pulse.
module calc_input_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [2:0] KEY,
    input  logic [7:0] SW,
    output logic [2:0] OP,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       LOAD,
    output logic       BUSY,
    output logic [7:0] COMMIT_CNT
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        COMMIT
    } state_t;

    // Last count value of the settle window; the commit decision happens on it.
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [10:0] sync1_q;
    logic [10:0] sync_s_q;
    logic [10:0] cand_q;
    logic [10:0] committed_q;
    logic [7:0]  cnt_q;
    state_t      state_q;

    // Two-flop synchronizer on the raw {KEY,SW} vector.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q  <= '0;
            sync_s_q <= '0;
        end else begin
            sync1_q  <= {KEY, SW};
            sync_s_q <= sync1_q;
        end
    end

    // Debounce FSM: capture a candidate, require it to hold, then commit it.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            committed_q <= '0;
            LOAD        <= 1'b0;
            COMMIT_CNT  <= '0;
        end else begin
            LOAD <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sync_s_q != committed_q) begin
                        cand_q  <= sync_s_q;
                        cnt_q   <= '0;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (sync_s_q != cand_q) begin
                        // Input moved: restart the settle window on the new value.
                        cand_q <= sync_s_q;
                        cnt_q  <= '0;
                    end else if (cnt_q < CNT_LAST) begin
                        cnt_q <= cnt_q + 8'd1;
                    end else if (cand_q != committed_q) begin
                        committed_q <= cand_q;
                        LOAD        <= 1'b1;
                        COMMIT_CNT  <= COMMIT_CNT + 8'd1;
                        state_q     <= COMMIT;
                    end else begin
                        // Glitch settled back onto the committed value: drop it.
                        state_q <= IDLE;
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Committed word is a straight bit pass-through of the sampled inputs.
    assign OP   = committed_q[10:8];
    assign A    = committed_q[7:4];
    assign B    = committed_q[3:0];
    assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Self-checking bench for calc_input_sequencer: directed scenarios plus random
// stimulus compared against a cycle-level behavioural model.
module tb_calc_input_sequencer;

    localparam int unsigned DEB = 4;

    logic       clk;
    logic       rst_n;
    logic [2:0] key;
    logic [7:0] sw;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       load;
    logic       busy;
    logic [7:0] commit_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    calc_input_sequencer #(
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .CLOCK_50  (clk),
        .RESET_N   (rst_n),
        .KEY       (key),
        .SW        (sw),
        .OP        (op),
        .A         (a),
        .B         (b),
        .LOAD      (load),
        .BUSY      (busy),
        .COMMIT_CNT(commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state. The model thinks in terms of "the word seen two
    // edges ago", "how long the current candidate has been stable", and
    // "whether we are watching, settling or cooling down after a commit".
    logic [10:0] m_pipe [2];
    logic [10:0] m_q;
    logic [10:0] m_cand;
    int unsigned m_age;
    bit          m_settling;
    bit          m_cool;
    bit          m_load;
    logic [7:0]  m_cnt;
    int unsigned m_loads;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pipe[0]  = '0;
        m_pipe[1]  = '0;
        m_q        = '0;
        m_cand     = '0;
        m_age      = 0;
        m_settling = 0;
        m_cool     = 0;
        m_load     = 0;
        m_cnt      = '0;
    endtask

    task automatic model_step(input logic [10:0] raw);
        logic [10:0] s;
        s      = m_pipe[1];
        m_load = 0;
        if (m_cool) begin
            m_cool = 0;
        end else if (!m_settling) begin
            if (s != m_q) begin
                m_cand     = s;
                m_age      = 0;
                m_settling = 1;
            end
        end else if (s != m_cand) begin
            m_cand = s;
            m_age  = 0;
        end else if (m_age + 1 < DEB) begin
            m_age++;
        end else begin
            m_settling = 0;
            if (m_cand != m_q) begin
                m_q    = m_cand;
                m_load = 1;
                m_cnt  = m_cnt + 8'd1;
                m_cool = 1;
            end
        end
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = raw;
    endtask

    task automatic compare_all();
        check("op", 32'(op), 32'(m_q[10:8]));
        check("a", 32'(a), 32'(m_q[7:4]));
        check("b", 32'(b), 32'(m_q[3:0]));
        check("load", 32'(load), 32'(m_load));
        check("busy", 32'(busy), 32'(m_settling || m_cool));
        check("commit_cnt", 32'(commit_cnt), 32'(m_cnt));
    endtask

    // One clock edge: advance the model, then sample 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step({key, sw});
        #1;
        if (load) m_loads++;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_op", 32'(op), 32'h0);
        check("rst_a", 32'(a), 32'h0);
        check("rst_b", 32'(b), 32'h0);
        check("rst_load", 32'(load), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cnt", 32'(commit_cnt), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned loads0;
        int unsigned last_change;
        int unsigned load_edge;
        rst_n   = 1'b1;
        key     = 3'b010;
        sw      = 8'hA5;
        m_loads = 0;
        model_reset();
        #3;
        // Async reset with arbitrary inputs and no clock edge in between.
        do_reset();

        // Basic commit: edge 1 is the first edge after release.
        key = 3'b000;
        sw  = 8'b0100_0011;
        for (int e = 1; e <= 9; e++) begin
            tick();
            check($sformatf("basic_load_e%0d", e), 32'(load), 32'(e == 7));
            check($sformatf("basic_busy_e%0d", e), 32'(busy), 32'(e >= 3 && e <= 7));
            if (e >= 7) begin
                check("basic_a", 32'(a), 32'h4);
                check("basic_b", 32'(b), 32'h3);
                check("basic_cnt", 32'(commit_cnt), 32'h1);
            end
        end

        // Glitch that returns to the committed value is discarded.
        loads0 = m_loads;
        sw = 8'b0100_0100;
        tick();
        tick();
        sw = 8'b0100_0011;
        for (int i = 0; i < 12; i++) tick();
        check("glitch_loads", m_loads - loads0, 0);
        check("glitch_a", 32'(a), 32'h4);
        check("glitch_b", 32'(b), 32'h3);
        check("glitch_cnt", 32'(commit_cnt), 32'h1);
        check("glitch_busy", 32'(busy), 32'h0);

        // Bounce: one LOAD, 7 edges after the last input change.
        loads0      = m_loads;
        load_edge   = 0;
        last_change = 0;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] nv;
            nv = ((i / 2) % 2 == 0) ? 8'b0111_0001 : 8'b0111_0000;
            if (nv != sw) last_change = i + 1;
            sw = nv;
            tick();
            if (load) load_edge = i + 1;
        end
        sw = 8'b0111_0001;
        for (int i = 10; i < 24; i++) begin
            tick();
            if (load) load_edge = i + 1;
        end
        check("bounce_loads", m_loads - loads0, 1);
        check("bounce_edge", load_edge, last_change + 6);
        check("bounce_a", 32'(a), 32'h7);
        check("bounce_b", 32'(b), 32'h1);

        // Reset two cycles into SETTLE, then a clean commit after release.
        do_reset();
        key    = 3'b101;
        sw     = 8'b1001_1001;
        loads0 = m_loads;
        for (int e = 1; e <= 5; e++) tick();
        check("mid_busy", 32'(busy), 32'h1);
        do_reset();
        check("mid_loads", m_loads - loads0, 0);
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("mid_load_e%0d", e), 32'(load), 32'(e == 7));
        end
        check("mid_op", 32'(op), 32'h5);
        check("mid_a", 32'(a), 32'h9);
        check("mid_b", 32'(b), 32'h9);

        // 256 commits sweeping every OP code; counter wraps back to 0.
        do_reset();
        loads0 = m_loads;
        for (int i = 0; i < 256; i++) begin
            key = 3'(i % 8);
            sw  = 8'($urandom_range(1, 255));
            for (int e = 0; e < 8; e++) tick();
            check("sweep_op", 32'(op), 32'(i % 8));
        end
        check("sweep_loads", m_loads - loads0, 256);
        check("sweep_wrap", 32'(commit_cnt), 32'h0);

        // Random segments of varying stability, with occasional resets.
        for (int seg = 0; seg < 300; seg++) begin
            int unsigned len;
            if ($urandom_range(0, 39) == 0) begin
                do_reset();
            end
            if ($urandom_range(0, 2) == 0) {key, sw} = m_q;
            else {key, sw} = 11'($urandom);
            len = $urandom_range(1, 10);
            for (int i = 0; i < int'(len); i++) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
